// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// default wait budget and round-robin pointer value.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int   TIMEOUT_DEFAULT = 15;
  localparam logic LAST_I          = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational; bit 0 = fetch, bit 1 = data.
// A contested request goes to the port that did not win most recently.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one memory port, one access at a time.
// mem_req follows a grant by one cycle; ack/err pulse combinationally with mem_ack or timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_ack,
  output logic                    i_err,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ack,
  output logic                    d_err,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  logic                  last;
  logic [1:0]            gnt;
  logic [CW-1:0]         wait_cnt;
  logic                  grant;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

  rr_arb2 u_rr (
    .req  ({d_req, i_req}),
    .last (last),
    .gnt  (gnt)
  );

  assign grant   = (state == IDLE) && (gnt != 2'b00);
  assign timeout = (wait_cnt == CW'(TIMEOUT));
  assign mem_req = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // mem_ack wins over a timeout landing in the same cycle
  always_comb begin
    state_nxt = state;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_err     = 1'b0;
    d_err     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt[1])      state_nxt = BUSY_D;
        else if (gnt[0]) state_nxt = BUSY_I;
      end
      BUSY_I: begin
        if (mem_ack) begin
          i_ack     = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          i_err     = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          d_ack     = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          d_err     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at grant; the memory side is zeroed again when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= LAST_I;
      wait_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant) begin
      last     <= gnt[1];
      wait_cnt <= '0;
      if (gnt[1]) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wstrb <= d_wstrb;
      end else begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end
    end else if (state != IDLE) begin
      if (state_nxt == IDLE) begin
        wait_cnt  <= '0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_ack) i_rdata_q <= mem_rdata;
      if (d_ack) d_rdata_q <= mem_rdata;
    end
  end

  assign i_rdata = i_ack ? mem_rdata : i_rdata_q;
  assign d_rdata = d_ack ? mem_rdata : d_rdata_q;

endmodule
